crc_stream_engine: RTL
======================

// Module: crc_stream_engine
// PURPOSE
//  Parametrised streaming CRC generator/checker: any CRC width/polynomial, multi-byte
//  data beats with partial last beat, frame-delimited valid/ready handshake.
//  Sits between a packet source (UART/SPI/Ethernet byte streams) and framing logic;
//  in check mode, compares the running register against the residue of a good frame.
// PARAMETERS
//  CRC_WIDTH   16          CRC register width, 8..32
//  POLY        16'h1021    generator polynomial, normal form, implicit x^CRC_WIDTH
//  INIT        16'hFFFF    register value at reset, on i_Init and after each frame
//  DATA_WIDTH  8           beat width, multiple of 8, 8..64; NB = DATA_WIDTH/8 bytes
//  REFLECT_IN  0           1: process each byte LSB-first; 0: MSB-first
//  REFLECT_OUT 0           1: bit-reverse the register before XOR_OUT
//  XOR_OUT     16'h0000    XORed onto the (reflected) register to form o_CRC
//  RESIDUE     16'h0000    raw register value after a good frame with its CRC appended
// PORTS
//  i_Clk       in   1           clock
//  i_Rst_n     in   1           asynchronous, active-low reset
//  i_Init      in   1           synchronous abort/re-initialise; overrides everything
//  i_Valid     in   1           beat valid
//  o_Ready     out  1           engine accepts a beat; beat taken when i_Valid & o_Ready
//  i_Data      in   DATA_WIDTH  byte 0 = i_Data[7:0], processed first
//  i_Keep      in   NB          byte enables, sampled on the last beat only, contiguous from bit 0
//  i_Last      in   1           marks the final beat of a frame
//  o_CRC       out  CRC_WIDTH   final CRC (reflect/xor applied), held until the next frame completes
//  o_Match     out  1           raw register == RESIDUE at frame end; held with o_CRC
//  o_Done      out  1           one-cycle pulse: o_CRC/o_Match updated this cycle
//  o_Busy      out  1           high while in S_RUN (at least one beat accepted, no last yet)
// BEHAVIOUR
//  - Reset: register=INIT, state S_IDLE, o_CRC=0, o_Match=0, o_Done=0, o_Busy=0.
//  - FSM: S_IDLE -(accepted beat, !i_Last)-> S_RUN; S_IDLE/S_RUN -(accepted beat, i_Last)-> S_DONE;
//    S_DONE -> S_IDLE unconditionally after 1 cycle. i_Init from any state -> S_IDLE.
//  - o_Ready = (state != S_DONE) & ~i_Init (combinational); one bubble cycle per frame.
//  - Non-last beats: all NB bytes processed, i_Keep ignored. Last beat: first popcount(i_Keep)
//    bytes processed; i_Keep==0 means no bytes (register unchanged, frame still completes).
//    Non-contiguous i_Keep is illegal; the bench asserts against it.
//  - Per byte: if REFLECT_IN, reverse the byte; reg = step(reg, byte): XOR byte into the top
//    8 bits, then 8 shift/conditional-XOR-POLY iterations, MSB-first, CRC_WIDTH bits.
//  - Last beat accepted at cycle T: in S_DONE at T+1, o_CRC = (REFLECT_OUT ? rev(reg) : reg)
//    ^ XOR_OUT, o_Match = (reg == RESIDUE), o_Done=1; register reloaded to INIT in that same cycle.
//  - o_Done and the new o_CRC/o_Match appear together, exactly 1 cycle after the last handshake.
//  - i_Init high: register <= INIT, state <= S_IDLE, no o_Done, o_CRC/o_Match keep their old
//    values; a beat presented that cycle is not accepted (o_Ready low).
//  - Single-beat frame (i_Last on the first beat) is legal: S_IDLE -> S_DONE directly.
//  - i_Valid low mid-frame: register and state hold indefinitely.
//  - Async reset mid-frame: all state to reset values immediately; the partial frame is lost.
// STRUCTURE
//  - crc_pkg: byte-reverse and CRC_WIDTH-reverse functions, crc_step function
//    (crc, byte, poly, width), state encoding constants S_IDLE/S_RUN/S_DONE.
//  - Sub-module crc_byte_lane: combinational one-byte update (reflect-in + crc_step);
//    NB instances chained; the last-beat mux selects chain tap popcount(i_Keep), non-last uses tap NB.
//  - Top: FSM, register, output transform/compare, handshake.
// TESTING
//  1 Defaults, "123456789" as 9 single-byte beats, last on '9' -> o_CRC=16'h29B1 at T+1, o_Done 1 cycle.
//  2 Defaults, "123456789",0x29,0xB1 -> o_Match=1; corrupt one data bit -> o_Match=0, o_CRC!=0.
//  3 CRC_WIDTH=32, POLY=32'h04C11DB7, INIT=32'hFFFFFFFF, REFLECT_IN/OUT=1, XOR_OUT=32'hFFFFFFFF,
//    DATA_WIDTH=32: beats "1234","5678","9"+i_Keep=4'b0001 -> o_CRC=32'hCBF43926.
//  4 Back-to-back frames with i_Valid held high -> o_Ready low exactly 1 cycle after each last;
//    second frame's CRC is independent of the first (INIT reload).
//  5 i_Init asserted mid-frame after "1234" with i_Valid high, then full "123456789" ->
//    no o_Done for the aborted frame; the following result is 16'h29B1.
//  6 Async reset mid-frame and last beat with i_Keep=0 -> reset values, then CRC of prior bytes only;
//    random valid gaps do not change any result.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared helpers for the streaming CRC engine: bit reversal, one-byte CRC update
// and the frame-state encoding.
package crc_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // Reverses the low 'width' bits of v; bits above width come back zero.
    function automatic logic [31:0] rev_w(input logic [31:0] v, input int width);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r >> (32 - width);
    endfunction

    // Work MSB-aligned in a 32-bit frame so one routine covers every width 8..32.
    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] b,
                                             input logic [31:0] poly, input int width);
        logic [31:0] c;
        logic [31:0] p;
        c = crc << (32 - width);
        p = poly << (32 - width);
        c[31:24] = c[31:24] ^ b;
        for (int i = 0; i < 8; i++) c = c[31] ? ((c << 1) ^ p) : (c << 1);
        return c >> (32 - width);
    endfunction

endpackage

// File: rtl/crc_stream_engine_byte_lane.sv
// Combinational one-byte CRC update; instances chain to cover a multi-byte beat.
module crc_byte_lane
    import crc_pkg::*;
#(
    parameter int                   CRC_WIDTH  = 16,
    parameter logic [CRC_WIDTH-1:0] POLY       = 16'h1021,
    parameter bit                   REFLECT_IN = 1'b0
) (
    input  logic [CRC_WIDTH-1:0] i_Crc,
    input  logic [7:0]           i_Byte,
    output logic [CRC_WIDTH-1:0] o_Crc
);

    logic [7:0] byte_in;

    assign byte_in = REFLECT_IN ? rev8(i_Byte) : i_Byte;
    assign o_Crc   = CRC_WIDTH'(crc_step(32'(i_Crc), byte_in, 32'(POLY), CRC_WIDTH));

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker with valid/ready beats, partial last beat and
// a registered result (o_CRC/o_Match) pulsed by o_Done one cycle after the last beat.
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int                   CRC_WIDTH   = 16,
    parameter logic [CRC_WIDTH-1:0] POLY        = 16'h1021,
    parameter logic [CRC_WIDTH-1:0] INIT        = 16'hFFFF,
    parameter int                   DATA_WIDTH  = 8,
    parameter bit                   REFLECT_IN  = 1'b0,
    parameter bit                   REFLECT_OUT = 1'b0,
    parameter logic [CRC_WIDTH-1:0] XOR_OUT     = 16'h0000,
    parameter logic [CRC_WIDTH-1:0] RESIDUE     = 16'h0000,
    localparam int                  NB          = DATA_WIDTH / 8
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic                  i_Init,
    input  logic                  i_Valid,
    output logic                  o_Ready,
    input  logic [DATA_WIDTH-1:0] i_Data,
    input  logic [NB-1:0]         i_Keep,
    input  logic                  i_Last,
    output logic [CRC_WIDTH-1:0]  o_CRC,
    output logic                  o_Match,
    output logic                  o_Done,
    output logic                  o_Busy
);

    logic [1:0]           state_q, state_d;
    logic [CRC_WIDTH-1:0] crc_q, crc_d;
    logic [CRC_WIDTH-1:0] out_crc_q, out_crc_d;
    logic                 match_q, match_d;

    logic [CRC_WIDTH-1:0] tap [NB+1];
    logic [CRC_WIDTH-1:0] last_crc;
    logic [CRC_WIDTH-1:0] final_crc;
    logic                 accept;
    int                   keep_cnt;

    assign tap[0] = crc_q;

    for (genvar g = 0; g < NB; g++) begin : g_lane
        crc_byte_lane #(
            .CRC_WIDTH (CRC_WIDTH),
            .POLY      (POLY),
            .REFLECT_IN(REFLECT_IN)
        ) u_lane (
            .i_Crc (tap[g]),
            .i_Byte(i_Data[8*g +: 8]),
            .o_Crc (tap[g+1])
        );
    end

    assign o_Ready  = (state_q != S_DONE) && !i_Init;
    assign accept   = i_Valid && o_Ready;
    assign keep_cnt = int'($countones(i_Keep));

    // Keep is contiguous from byte 0, so its popcount is the chain tap to use.
    always_comb begin
        last_crc = tap[0];
        for (int k = 1; k <= NB; k++) begin
            if (keep_cnt == k) last_crc = tap[k];
        end
        final_crc = (REFLECT_OUT ? CRC_WIDTH'(rev_w(32'(last_crc), CRC_WIDTH)) : last_crc)
                    ^ XOR_OUT;
    end

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        out_crc_d = out_crc_q;
        match_d   = match_q;
        if (i_Init) begin
            state_d = S_IDLE;
            crc_d   = INIT;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end else if (accept) begin
            if (i_Last) begin
                state_d   = S_DONE;
                crc_d     = INIT;
                out_crc_d = final_crc;
                match_d   = (last_crc == RESIDUE);
            end else begin
                state_d = S_RUN;
                crc_d   = tap[NB];
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= S_IDLE;
            crc_q     <= INIT;
            out_crc_q <= '0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            out_crc_q <= out_crc_d;
            match_q   <= match_d;
        end
    end

    assign o_CRC   = out_crc_q;
    assign o_Match = match_q;
    assign o_Done  = (state_q == S_DONE);
    assign o_Busy  = (state_q == S_RUN);

endmodule
